// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64 integer register file.
//   DATA_W   : register width in bits
//   ADDR_W   : register index width
//   NREGS    : number of architectural registers
//   ZERO_REG : index hardwired to zero (XZR)
package regfile_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NREGS    = 2 ** ADDR_W;
  localparam int unsigned ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  // Index-width form of ZERO_REG, so comparisons against indices stay width-matched.
  localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

endpackage

// File: rtl/regfile_wr32x64_decoder.sv
// One-hot write decoder: ADDR_W-bit index to NREGS enables, gated by en.
//   en     : input  global enable (RegWrite)
//   idx    : input  register index
//   onehot : output one-hot enable vector (all zero when en=0)
module decoder5_32
  import regfile_pkg::*;
(
  input  logic             en,
  input  reg_idx_t         idx,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = en;
  end

endmodule

// File: rtl/regfile_wr32x64.sv
// 32-entry x 64-bit integer register file with one write port, two
// combinational read ports, XZR (index 31) reading as zero, and a
// same-cycle write-to-read bypass.
//   clk           : input  clock, registers update on posedge
//   reset         : input  asynchronous active-high clear of all registers
//   RegWrite      : input  write enable
//   WriteRegister : input  destination index
//   WriteData     : input  data to write
//   ReadRegister1 : input  read port 1 index
//   ReadRegister2 : input  read port 2 index
//   ReadData1     : output read port 1 data (combinational)
//   ReadData2     : output read port 2 data (combinational)
module regfile_wr32x64
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [NREGS-1:0] wr_en;
  word_t            regs [NREGS];

  decoder5_32 u_wr_dec (
    .en     (RegWrite),
    .idx    (WriteRegister),
    .onehot (wr_en)
  );

  // Index ZERO_REG has no storage; its slot is a constant zero, so the
  // read mux needs no special case beyond the bypass qualifier.
  for (genvar i = 0; i < NREGS; i++) begin : g_word
    if (i == ZERO_REG) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_ff
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          regs[i] <= '0;
        else if (wr_en[i])
          regs[i] <= WriteData;
      end
    end
  end

  logic byp1, byp2;

  always_comb begin
    byp1 = RegWrite && !reset && (WriteRegister != ZERO_IDX)
           && (WriteRegister == ReadRegister1);
    byp2 = RegWrite && !reset && (WriteRegister != ZERO_IDX)
           && (WriteRegister == ReadRegister2);
    ReadData1 = byp1 ? WriteData : regs[ReadRegister1];
    ReadData2 = byp2 ? WriteData : regs[ReadRegister2];
  end

endmodule

// File: tb/tb_regfile_wr32x64.sv
// Self-checking bench for regfile_wr32x64: expected read data is queued as
// each read is driven and popped when the outputs are sampled.
module tb_regfile_wr32x64;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  regfile_wr32x64 dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  typedef struct {
    logic [63:0] e1;
    logic [63:0] e2;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] shadow [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      check_eq({tag, "_rd1"}, ReadData1, e.e1);
      check_eq({tag, "_rd2"}, ReadData2, e.e2);
    end
  endtask

  task automatic expect_read(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                             input logic [63:0] e1, input logic [63:0] e2);
    ReadRegister1 = r1;
    ReadRegister2 = r2;
    sbq.push_back('{e1, e2});
    #1;
    sample(tag);
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [63:0] data);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    WriteData     = data;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    if (idx != 5'd31) shadow[idx] = data;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      expect_read(tag, 5'(i), 5'(30 - i), shadow[i], shadow[30 - i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    // Reset held with a pending write to index 5
    reset         = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd5;
    WriteData     = 64'hDEAD;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd0;
    repeat (2) begin
      @(negedge clk);
      expect_read("rst_hold", 5'd5, 5'd0, 64'd0, 64'd0);
    end
    @(negedge clk);
    reset    = 1'b0;
    RegWrite = 1'b0;
    sweep("rst_clear");

    // Fill 0..30, checking same-cycle bypass on port 1 as each write is presented
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'(i);
      WriteData     = 64'h1000 + 64'(i);
      expect_read("wr_bypass", 5'(i), 5'd31, 64'h1000 + 64'(i), 64'd0);
      @(posedge clk);
      #1;
      shadow[i] = 64'h1000 + 64'(i);
    end
    RegWrite = 1'b0;
    sweep("wr_readback");

    // XZR write is discarded
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd31;
    WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
    expect_read("xzr_same", 5'd31, 5'd31, 64'd0, 64'd0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    @(negedge clk);
    expect_read("xzr_next", 5'd31, 5'd31, 64'd0, 64'd0);
    sweep("xzr_others");

    // Bypass priority over stored value
    do_write(5'd7, 64'd10);
    @(negedge clk);
    expect_read("byp_pre", 5'd7, 5'd7, 64'd10, 64'd10);
    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = -64'd2418;
    expect_read("byp_same", 5'd7, 5'd7, -64'd2418, -64'd2418);
    @(posedge clk);
    #1;
    RegWrite  = 1'b0;
    shadow[7] = -64'd2418;
    @(negedge clk);
    expect_read("byp_after", 5'd7, 5'd7, -64'd2418, -64'd2418);

    // Enable gating: RegWrite=0 leaves reg 3 alone and does not bypass
    do_write(5'd3, 64'd100);
    @(negedge clk);
    RegWrite      = 1'b0;
    WriteRegister = 5'd3;
    WriteData     = 64'd64;
    expect_read("gate_same", 5'd3, 5'd3, 64'd100, 64'd100);
    repeat (5) @(posedge clk);
    @(negedge clk);
    expect_read("gate_after", 5'd3, 5'd2, 64'd100, 64'h1002);

    // Async reset pulse between edges
    for (int i = 1; i <= 4; i++) do_write(5'(i), 64'hA5A5_0000 + 64'(i));
    @(negedge clk);
    expect_read("arst_pre", 5'd1, 5'd4, 64'hA5A5_0001, 64'hA5A5_0004);
    reset = 1'b1;
    expect_read("arst_12", 5'd1, 5'd2, 64'd0, 64'd0);
    expect_read("arst_34", 5'd3, 5'd4, 64'd0, 64'd0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    sweep("arst_all");

    // First write after reset behaves normally
    do_write(5'd9, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    expect_read("post_rst_wr", 5'd9, 5'd8, 64'h0123_4567_89AB_CDEF, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
